// File: rtl/addr_region_router.sv
// addr_region_router: decodes CPU requests into base/size windows, rebases to a local offset and
// runs a registered req/ack handshake with per-access timeout and sticky first-fault capture.
module addr_region_router #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int NUM_REGIONS = 2,
    parameter logic [NUM_REGIONS*AW-1:0] REGION_BASE = {32'h0020_0000, 32'h0},
    parameter logic [NUM_REGIONS*AW-1:0] REGION_SIZE = {32'h0080_0000, 32'h0010_0000},
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      m_req_valid,
    output logic                      m_req_ready,
    input  logic [AW-1:0]             m_addr,
    input  logic                      m_we,
    input  logic [DW-1:0]             m_wdata,
    input  logic [DW/8-1:0]           m_wstrb,
    output logic                      m_resp_valid,
    output logic [DW-1:0]             m_rdata,
    output logic                      m_resp_err,
    output logic [NUM_REGIONS-1:0]    s_sel,
    output logic [AW-1:0]             s_addr,
    output logic                      s_we,
    output logic [DW-1:0]             s_wdata,
    output logic [DW/8-1:0]           s_wstrb,
    input  logic [NUM_REGIONS-1:0]    s_ack,
    input  logic [NUM_REGIONS*DW-1:0] s_rdata,
    output logic                      fault_valid,
    output logic [AW-1:0]             fault_addr,
    input  logic                      fault_clr
);
    localparam int IW = NUM_REGIONS > 1 ? $clog2(NUM_REGIONS) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [AW-1:0] req_addr;
    logic          hit;
    logic [IW-1:0] hit_idx;
    logic [AW-1:0] hit_off;
    logic          ack;
    logic          expired;
    logic          err_evt;
    logic [AW-1:0] err_addr;

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        hit_off = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ({1'b0, m_addr} >= {1'b0, REGION_BASE[i*AW +: AW]} &&
                {1'b0, m_addr} < {1'b0, REGION_BASE[i*AW +: AW]} + {1'b0, REGION_SIZE[i*AW +: AW]}) begin
                hit = 1'b1;
                hit_idx = IW'(i);
                hit_off = m_addr - REGION_BASE[i*AW +: AW];
            end
        end
    end

    assign ack      = s_ack[idx];
    assign expired  = cnt == CW'(TIMEOUT - 1);
    assign err_evt  = (state == IDLE && m_req_valid && !hit) || (state == ACCESS && !ack && expired);
    assign err_addr = state == IDLE ? m_addr : req_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            req_addr     <= '0;
            m_req_ready  <= 1'b1;
            m_resp_valid <= 1'b0;
            m_resp_err   <= 1'b0;
            m_rdata      <= '0;
            s_sel        <= '0;
            s_addr       <= '0;
            s_we         <= 1'b0;
            s_wdata      <= '0;
            s_wstrb      <= '0;
            fault_valid  <= 1'b0;
            fault_addr   <= '0;
        end else begin
            case (state)
                IDLE: if (m_req_valid) begin
                    m_req_ready <= 1'b0;
                    req_addr    <= m_addr;
                    if (hit) begin
                        state   <= ACCESS;
                        s_sel   <= NUM_REGIONS'(1) << hit_idx;
                        idx     <= hit_idx;
                        s_addr  <= hit_off;
                        s_we    <= m_we;
                        s_wdata <= m_wdata;
                        s_wstrb <= m_wstrb;
                        cnt     <= '0;
                    end else begin
                        state        <= RESP;
                        m_resp_valid <= 1'b1;
                        m_resp_err   <= 1'b1;
                        m_rdata      <= '0;
                    end
                end
                ACCESS: if (ack || expired) begin
                    state        <= RESP;
                    m_resp_valid <= 1'b1;
                    m_resp_err   <= !ack;
                    m_rdata      <= (ack && !s_we) ? s_rdata[idx*DW +: DW] : '0;
                    s_sel        <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP: begin
                    state        <= IDLE;
                    m_resp_valid <= 1'b0;
                    m_resp_err   <= 1'b0;
                    m_req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            // A new error in the same cycle as a clear re-arms with the new address.
            if (err_evt && (!fault_valid || fault_clr)) begin
                fault_valid <= 1'b1;
                fault_addr  <= err_addr;
            end else if (fault_clr) begin
                fault_valid <= 1'b0;
                fault_addr  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_addr_region_router.sv
// tb_addr_region_router: directed scenarios for decode, handshake, timeout, reset and fault capture.
module tb_addr_region_router;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_req_valid = 1'b0;
    logic        m_req_ready;
    logic [31:0] m_addr = '0;
    logic        m_we = 1'b0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_wstrb = '0;
    logic        m_resp_valid;
    logic [31:0] m_rdata;
    logic        m_resp_err;
    logic [1:0]  s_sel;
    logic [31:0] s_addr;
    logic        s_we;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_ack = '0;
    logic [63:0] s_rdata = '0;
    logic        fault_valid;
    logic [31:0] fault_addr;
    logic        fault_clr = 1'b0;

    int total = 0;
    int bad = 0;

    addr_region_router dut (
        .clk(clk), .rst_n(rst_n),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_addr(m_addr), .m_we(m_we),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_resp_valid(m_resp_valid), .m_rdata(m_rdata),
        .m_resp_err(m_resp_err), .s_sel(s_sel), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ack(s_ack), .s_rdata(s_rdata), .fault_valid(fault_valid),
        .fault_addr(fault_addr), .fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] st);
        m_req_valid = 1'b1;
        m_addr = a;
        m_we = we;
        m_wdata = wd;
        m_wstrb = st;
        step();
        m_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total++;
        if ({m_req_ready, m_resp_valid, m_resp_err, s_sel, fault_valid} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=100000", {m_req_ready, m_resp_valid, m_resp_err, s_sel, fault_valid});
        end
        total++;
        if ({m_rdata, s_addr, s_wdata, fault_addr, s_we, s_wstrb} !== '0) begin
            bad++;
            $display("FAIL reset_data rdata=%h s_addr=%h fault_addr=%h want all zero", m_rdata, s_addr, fault_addr);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_read();
        issue(32'h0000_0100, 1'b0, '0, 4'hF);
        total++;
        if ({s_sel, s_addr, m_req_ready, m_resp_valid} !== {2'b01, 32'h100, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL read_sel sel=%b addr=%h rdy=%b rv=%b want 01/100/0/0", s_sel, s_addr, m_req_ready, m_resp_valid);
        end
        s_ack = 2'b01;
        s_rdata = {32'h1111_2222, 32'hDEAD_BEEF};
        step();
        s_ack = '0;
        total++;
        if ({m_resp_valid, m_resp_err, m_rdata, s_sel} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 2'b00}) begin
            bad++;
            $display("FAIL read_resp rv=%b err=%b rdata=%h sel=%b want 1/0/deadbeef/00", m_resp_valid, m_resp_err, m_rdata, s_sel);
        end
        step();
        total++;
        if ({m_resp_valid, m_req_ready} !== 2'b01) begin
            bad++;
            $display("FAIL read_pulse rv=%b rdy=%b want 0/1", m_resp_valid, m_req_ready);
        end
    endtask

    task automatic test_write();
        issue(32'h0020_0004, 1'b1, 32'h1234_5678, 4'b0011);
        total++;
        if ({s_sel, s_addr, s_we, s_wstrb, s_wdata} !== {2'b10, 32'h4, 1'b1, 4'b0011, 32'h1234_5678}) begin
            bad++;
            $display("FAIL write_fields sel=%b addr=%h we=%b strb=%b wdata=%h", s_sel, s_addr, s_we, s_wstrb, s_wdata);
        end
        s_ack = 2'b10;
        s_rdata = {32'hCAFE_F00D, 32'h0};
        step();
        s_ack = '0;
        total++;
        if ({m_resp_valid, m_resp_err, m_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL write_resp rv=%b err=%b rdata=%h want 1/0/0", m_resp_valid, m_resp_err, m_rdata);
        end
        step();
    endtask

    task automatic test_boundary();
        logic [31:0] addrs [5] = '{32'h000F_FFFC, 32'h0010_0000, 32'h009F_FFFC, 32'h00A0_0000, 32'hFFFF_FFFC};
        logic [1:0]  sels [5]  = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
        logic [31:0] offs [5]  = '{32'h000F_FFFC, 32'h0, 32'h007F_FFFC, 32'h0, 32'h0};
        for (int i = 0; i < 5; i++) begin
            issue(addrs[i], 1'b0, '0, 4'hF);
            if (sels[i] != 2'b00) begin
                total++;
                if ({s_sel, s_addr} !== {sels[i], offs[i]}) begin
                    bad++;
                    $display("FAIL bound_sel[%0d] sel=%b addr=%h want %b/%h", i, s_sel, s_addr, sels[i], offs[i]);
                end
                s_ack = sels[i];
                step();
                s_ack = '0;
            end
            total++;
            if ({m_resp_valid, m_resp_err, s_sel} !== {1'b1, sels[i] == 2'b00, 2'b00}) begin
                bad++;
                $display("FAIL bound_resp[%0d] rv=%b err=%b sel=%b want 1/%b/00", i, m_resp_valid, m_resp_err, s_sel, sels[i] == 2'b00);
            end
            step();
        end
        total++;
        if ({fault_valid, fault_addr} !== {1'b1, 32'h0010_0000}) begin
            bad++;
            $display("FAIL bound_fault valid=%b addr=%h want 1/00100000", fault_valid, fault_addr);
        end
    endtask

    task automatic test_timeout();
        int early = 0;
        issue(32'h0030_0000, 1'b0, '0, 4'hF);
        for (int i = 0; i < 15; i++) begin
            step();
            if (m_resp_valid !== 1'b0 || s_sel !== 2'b10) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL timeout_early got=%0d early cycles want=0", early);
        end
        step();
        total++;
        if ({m_resp_valid, m_resp_err, m_rdata, s_sel} !== {1'b1, 1'b1, 32'h0, 2'b00}) begin
            bad++;
            $display("FAIL timeout_resp rv=%b err=%b rdata=%h sel=%b want 1/1/0/00", m_resp_valid, m_resp_err, m_rdata, s_sel);
        end
        step();
    endtask

    task automatic test_late_ack();
        int early = 0;
        issue(32'h0030_0000, 1'b0, '0, 4'hF);
        s_rdata = {32'h5A5A_5A5A, 32'hBAD0_BAD0};
        for (int i = 0; i < 15; i++) begin
            s_ack = (i % 3 == 0) ? 2'b01 : 2'b00;
            step();
            if (m_resp_valid !== 1'b0) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL spurious_ack got=%0d early responses want=0", early);
        end
        s_ack = 2'b10;
        step();
        s_ack = '0;
        total++;
        if ({m_resp_valid, m_resp_err, m_rdata} !== {1'b1, 1'b0, 32'h5A5A_5A5A}) begin
            bad++;
            $display("FAIL late_ack rv=%b err=%b rdata=%h want 1/0/5a5a5a5a", m_resp_valid, m_resp_err, m_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        issue(32'h0000_0100, 1'b0, '0, 4'hF);
        rst_n = 1'b0;
        #1;
        total++;
        if ({s_sel, m_resp_valid, m_req_ready, fault_valid} !== 5'b00010) begin
            bad++;
            $display("FAIL reset_mid got=%b want=00010", {s_sel, m_resp_valid, m_req_ready, fault_valid});
        end
        step();
        rst_n = 1'b1;
        s_ack = 2'b01;
        for (int i = 0; i < 4; i++) begin
            step();
            if (m_resp_valid !== 1'b0) pulses++;
        end
        s_ack = '0;
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL reset_no_resp got=%0d pulses want=0", pulses);
        end
    endtask

    task automatic test_fault_clr();
        issue(32'h00A0_0000, 1'b0, '0, 4'hF);
        step();
        total++;
        if ({fault_valid, fault_addr} !== {1'b1, 32'h00A0_0000}) begin
            bad++;
            $display("FAIL fault_first valid=%b addr=%h want 1/00a00000", fault_valid, fault_addr);
        end
        fault_clr = 1'b1;
        issue(32'hFFFF_FFFC, 1'b0, '0, 4'hF);
        fault_clr = 1'b0;
        total++;
        if ({fault_valid, fault_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            bad++;
            $display("FAIL fault_set_wins valid=%b addr=%h want 1/fffffffc", fault_valid, fault_addr);
        end
        step();
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        total++;
        if ({fault_valid, fault_addr} !== {1'b0, 32'h0}) begin
            bad++;
            $display("FAIL fault_clear valid=%b addr=%h want 0/0", fault_valid, fault_addr);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_boundary();
        test_timeout();
        test_late_ack();
        test_reset_mid();
        test_fault_clr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
